wb_uart_rx_multi: RTL and testbench

Parametrised UART receiver with an internal receive FIFO and a Wishbone-lite read port.
- Successor to the fixed 8N1 receiver: configurable data width, optional parity, 1 or 2 stop bits.
- 16x oversampling with 3-sample majority vote and false-start rejection.
- Sticky framing, parity and overrun error flags, readable through a status register.
- Sits between the board RX pin and the Z80 I/O bus bridge.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/wb_uart_rx_multi.sv | 200 ++++++++++++++++++++
 tb/tb_wb_uart_rx_multi.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver state encoding, parity codes, status register bit
// positions, oversampling constants and the 3-sample majority helper.
// No ports; imported with `import uart_pkg::*;`.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK,
    S_PUSH
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Status register layout: {3'b0, OE, PE, FE, full, empty}
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_FE    = 2;
  localparam int ST_PE    = 3;
  localparam int ST_OE    = 4;

  // Oversampling: 16 ticks per bit, bit value voted from ticks 7, 8 and 9.
  localparam int OSR       = 16;
  localparam int SAMPLE_T0 = 7;
  localparam int SAMPLE_T1 = 8;
  localparam int SAMPLE_T2 = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO with fall-through (combinational) head.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push, din       write request and data (ignored when full without pop)
//   pop, dout       read request and current head (ignored when empty)
//   count           occupancy, AW+1 bits
//   empty, full     registered flags derived from the next count
module sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  logic [AW:0]   count_next;

  // A push into a full FIFO is allowed only when a pop frees a slot this cycle.
  assign do_push    = push & (~full | pop);
  assign do_pop     = pop & ~empty;
  assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout       = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == (AW+1)'(DEPTH));
    end
  end

  // NOTE: storage has no reset; contents are only observable after a push,
  // and leaving it out keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_uart_rx_multi.sv
// Parametrised UART receiver with receive FIFO and Wishbone-lite read port.
// 16x oversampling, 3-sample majority vote, false-start rejection, sticky
// framing/parity/overrun flags.
// Optional feature macro: UART_RX_PARITY_EN (when undefined, PARITY is
// ignored, no parity bit is expected and PE reads as 0).
// Ports:
//   i_clk, i_reset           clock, asynchronous active-high reset
//   i_wb_cyc, i_wb_stb       bus request (both high)
//   i_wb_addr                0 = data (pops FIFO), 1 = status (clears flags)
//   o_wb_data, o_wb_ack      read data and one-cycle acknowledge
//   o_wb_stall               always 0
//   uart_rx                  asynchronous serial input, idle high
//   uart_empty, o_fifo_full  FIFO flags
//   o_rx_err                 OR of sticky FE, PE, OE
module wb_uart_rx_multi
  import uart_pkg::*;
#(
  parameter int DATA_BITS     = 8,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1,
  parameter int OSR_DIV       = 163,
  parameter int OSR_DIV_WIDTH = 8,
  parameter int FIFO_AW       = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wb_cyc,
  input  logic       i_wb_stb,
  input  logic       i_wb_addr,
  output logic [7:0] o_wb_data,
  output logic       o_wb_ack,
  output logic       o_wb_stall,
  input  logic       uart_rx,
  output logic       uart_empty,
  output logic       o_fifo_full,
  output logic       o_rx_err
);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = (PARITY != PAR_NONE);
`else
  localparam bit PAR_ON = 1'b0;
`endif
  localparam int OS_W  = $clog2(OSR);
  localparam int DEPTH = 1 << FIFO_AW;

  state_t                   state;
  logic                     rx_meta, rx_sync;
  logic [OSR_DIV_WIDTH-1:0] div_cnt;
  logic [OS_W-1:0]          os_cnt;
  logic [2:0]               bit_cnt;
  logic                     stop_cnt;
  logic [7:0]               shreg;
  logic                     s7, s8, pe_pend;
  logic                     fe, pe, oe;

  logic       tick, at_eval, voted, par_bad;
  logic       req, pop, push_req, accept, clr;
  logic [7:0] rx_byte, head, status;
  logic [FIFO_AW:0] count;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  assign tick    = (state != S_IDLE) && (div_cnt == OSR_DIV_WIDTH'(OSR_DIV - 1));
  assign at_eval = tick && (os_cnt == OS_W'(SAMPLE_T2));
  // Tick-9 sample is taken live from the synchroniser.
  assign voted   = maj3(s7, s8, rx_sync);
  // Data bits sit in the top of shreg and zeros below, so ^shreg is data parity.
  assign par_bad = (PARITY == PAR_ODD) ? ~(^shreg ^ voted) : (^shreg ^ voted);
  assign rx_byte = shreg >> (8 - DATA_BITS);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      shreg    <= '0;
      s7       <= 1'b1;
      s8       <= 1'b1;
      pe_pend  <= 1'b0;
    end else begin
      if (state != S_IDLE) begin
        if (tick) begin
          div_cnt <= '0;
          os_cnt  <= os_cnt + 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (tick && os_cnt == OS_W'(SAMPLE_T0)) s7 <= rx_sync;
      if (tick && os_cnt == OS_W'(SAMPLE_T1)) s8 <= rx_sync;

      unique case (state)
        S_IDLE: if (!rx_sync) begin
          state   <= S_START;
          div_cnt <= '0;
          os_cnt  <= '0;
        end
        S_START: if (at_eval) begin
          if (voted) begin
            state <= S_IDLE;
          end else begin
            state   <= S_DATA;
            bit_cnt <= '0;
            shreg   <= '0;
            pe_pend <= 1'b0;
          end
        end
        S_DATA: if (at_eval) begin
          shreg <= {voted, shreg[7:1]};
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            state    <= PAR_ON ? S_PARITY : S_STOP;
            stop_cnt <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_PARITY: if (at_eval) begin
          pe_pend <= par_bad;
          state   <= S_STOP;
        end
        S_STOP: if (at_eval) begin
          if (!voted)                              state <= S_BREAK;
          else if (stop_cnt == 1'(STOP_BITS - 1))  state <= S_PUSH;
          else                                     stop_cnt <= 1'b1;
        end
        S_BREAK: if (rx_sync) state <= S_IDLE;
        S_PUSH:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req      = i_wb_cyc & i_wb_stb;
  assign pop      = req & ~i_wb_addr & ~uart_empty;
  assign clr      = req & i_wb_addr;
  assign push_req = (state == S_PUSH);
  assign accept   = push_req & ((count < (FIFO_AW+1)'(DEPTH)) | pop);

  sync_fifo #(.DW(8), .AW(FIFO_AW)) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (accept),
    .pop   (pop),
    .din   (rx_byte),
    .dout  (head),
    .count (count),
    .empty (uart_empty),
    .full  (o_fifo_full)
  );

  // Sticky flags: a set in the same cycle as a status-read clear wins.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fe <= 1'b0;
      pe <= 1'b0;
      oe <= 1'b0;
    end else begin
      fe <= (fe & ~clr) | (state == S_STOP && at_eval && !voted);
      pe <= (pe & ~clr) | (PAR_ON & push_req & pe_pend);
      oe <= (oe & ~clr) | (push_req & ~accept);
    end
  end

  // NOTE: every always_comb output gets a default first so no path can
  // infer a latch.
  always_comb begin
    status           = '0;
    status[ST_EMPTY] = uart_empty;
    status[ST_FULL]  = o_fifo_full;
    status[ST_FE]    = fe;
    status[ST_PE]    = pe;
    status[ST_OE]    = oe;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_wb_ack  <= 1'b0;
      o_wb_data <= '0;
    end else begin
      o_wb_ack <= req;
      if (req) o_wb_data <= i_wb_addr ? status : (uart_empty ? 8'h00 : head);
    end
  end

  assign o_wb_stall = 1'b0;
  assign o_rx_err   = fe | pe | oe;

endmodule

// File: tb/tb_wb_uart_rx_multi.sv
// Directed bench for wb_uart_rx_multi.
// Instance A: 8N1, OSR_DIV = 2, 4-entry FIFO.
// Instance B: 7 data bits, even parity (only with UART_RX_PARITY_EN), 2 stop bits.
module tb_wb_uart_rx_multi;

  localparam int BIT_CLKS = 32; // 16 ticks x OSR_DIV 2

`ifdef UART_RX_PARITY_EN
  localparam bit B_PAR = 1'b1;
`else
  localparam bit B_PAR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_cyc = 1'b0, a_stb = 1'b0, a_addr = 1'b0, a_rx = 1'b1;
  logic       b_cyc = 1'b0, b_stb = 1'b0, b_addr = 1'b0, b_rx = 1'b1;
  logic [7:0] a_data, b_data;
  logic       a_ack, a_stall, a_empty, a_full, a_err;
  logic       b_ack, b_stall, b_empty, b_full, b_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_uart_rx_multi #(
    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
    .OSR_DIV(2), .OSR_DIV_WIDTH(8), .FIFO_AW(2)
  ) u_a (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(a_cyc), .i_wb_stb(a_stb), .i_wb_addr(a_addr),
    .o_wb_data(a_data), .o_wb_ack(a_ack), .o_wb_stall(a_stall),
    .uart_rx(a_rx), .uart_empty(a_empty), .o_fifo_full(a_full), .o_rx_err(a_err)
  );

  wb_uart_rx_multi #(
    .DATA_BITS(7), .PARITY(1), .STOP_BITS(2),
    .OSR_DIV(2), .OSR_DIV_WIDTH(8), .FIFO_AW(4)
  ) u_b (
    .i_clk(clk), .i_reset(rst),
    .i_wb_cyc(b_cyc), .i_wb_stb(b_stb), .i_wb_addr(b_addr),
    .o_wb_data(b_data), .o_wb_ack(b_ack), .o_wb_stall(b_stall),
    .uart_rx(b_rx), .uart_empty(b_empty), .o_fifo_full(b_full), .o_rx_err(b_err)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Called at a negedge; holds the level for one bit period.
  task automatic drive_bit(input bit inst, input logic b);
    if (inst) b_rx = b;
    else      a_rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input bit inst, input logic [7:0] d, input int nbits,
                            input bit par_en, input int nstop, input bit last_stop);
    logic [7:0] dv;
    logic       par;
    dv  = d;
    par = 1'b0;
    drive_bit(inst, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      drive_bit(inst, dv[i]);
      par = par ^ dv[i];
    end
    if (par_en) drive_bit(inst, par);  // even parity
    for (int s = 0; s < nstop; s++)
      drive_bit(inst, (s == nstop - 1) ? last_stop : 1'b1);
  endtask

  // One request cycle; checks ack/data the cycle after, and ack low after that.
  task automatic wb_read(input bit inst, input bit addr, input logic [7:0] exp,
                         input string tag);
    if (inst) begin b_cyc = 1'b1; b_stb = 1'b1; b_addr = addr; end
    else      begin a_cyc = 1'b1; a_stb = 1'b1; a_addr = addr; end
    @(negedge clk);
    if (inst) begin b_cyc = 1'b0; b_stb = 1'b0; end
    else      begin a_cyc = 1'b0; a_stb = 1'b0; end
    check({tag, "_ack"},  inst ? b_ack : a_ack, 8'h01);
    check({tag, "_data"}, inst ? b_data : a_data, exp);
    @(negedge clk);
    check({tag, "_ack_drop"}, inst ? b_ack : a_ack, 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack",   a_ack,   8'h00);
    check("rst_data",  a_data,  8'h00);
    check("rst_empty", a_empty, 8'h01);
    check("rst_full",  a_full,  8'h00);
    check("rst_err",   a_err,   8'h00);
    check("rst_stall", a_stall, 8'h00);
    check("rst_b_empty", b_empty, 8'h01);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Basic 8N1 frame
    send_frame(0, 8'hA5, 8, 1'b0, 1, 1'b1);
    check("a5_not_empty", a_empty, 8'h00);
    wb_read(0, 1'b0, 8'hA5, "a5_read");
    check("a5_empty_after", a_empty, 8'h01);
    wb_read(0, 1'b0, 8'h00, "empty_read");
    wb_read(0, 1'b1, 8'h01, "status_idle");

    // Short glitch rejected as false start
    a_rx = 1'b0;
    repeat (6) @(negedge clk);
    a_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_empty", a_empty, 8'h01);
    check("glitch_err",   a_err,   8'h00);
    wb_read(0, 1'b1, 8'h01, "glitch_status");

    // Framing error followed by a long break
    send_frame(0, 8'h3C, 8, 1'b0, 1, 1'b0);
    repeat (40 * BIT_CLKS) @(negedge clk);
    check("fe_empty", a_empty, 8'h01);
    check("fe_err",   a_err,   8'h01);
    wb_read(0, 1'b1, 8'h05, "fe_status");
    check("fe_err_cleared", a_err, 8'h00);
    a_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(0, 8'h55, 8, 1'b0, 1, 1'b1);
    wb_read(0, 1'b0, 8'h55, "after_break");

    // Overflow: five back-to-back frames into a 4-entry FIFO
    for (int i = 1; i <= 5; i++) begin
      send_frame(0, 8'(i * 8'h11), 8, 1'b0, 1, 1'b1);
      if (i == 4) check("full_after_4", a_full, 8'h01);
    end
    check("ovf_err", a_err, 8'h01);
    wb_read(0, 1'b1, 8'h12, "ovf_status");
    wb_read(0, 1'b0, 8'h11, "ovf_rd1");
    wb_read(0, 1'b0, 8'h22, "ovf_rd2");
    wb_read(0, 1'b0, 8'h33, "ovf_rd3");
    wb_read(0, 1'b0, 8'h44, "ovf_rd4");
    check("ovf_drained", a_empty, 8'h01);
    check("ovf_err_cleared", a_err, 8'h00);

    // Instance B: 7 data bits, 2 stop bits
    send_frame(1, 8'h41, 7, B_PAR, 2, 1'b1);
    send_frame(1, 8'hFF, 7, B_PAR, 2, 1'b1);
    check("b_err_clean", b_err, 8'h00);
    wb_read(1, 1'b0, 8'h41, "b_rd41");
    wb_read(1, 1'b0, 8'h7F, "b_rd7f");
    // Second stop bit low must raise FE
    send_frame(1, 8'h2A, 7, B_PAR, 2, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    check("b_stop2_empty", b_empty, 8'h01);
    wb_read(1, 1'b1, 8'h05, "b_stop2_status");
    b_rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x41 has even weight, so the correct even parity bit is 0; send 1.
    b_rx = 1'b0; repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      b_rx = (i == 0 || i == 6); repeat (BIT_CLKS) @(negedge clk);
    end
    b_rx = 1'b1; repeat (3 * BIT_CLKS) @(negedge clk);  // bad parity + 2 stops
    check("pe_err", b_err, 8'h01);
    wb_read(1, 1'b1, 8'h08, "pe_status");
    wb_read(1, 1'b1, 8'h00, "pe_status2");
    wb_read(1, 1'b0, 8'h41, "pe_byte");
`endif

    // Reset in the middle of a frame
    send_frame(0, 8'h99, 8, 1'b0, 1, 1'b1);
    check("pre_rst_not_empty", a_empty, 8'h00);
    drive_bit(0, 1'b0);  // start
    drive_bit(0, 1'b1);  // 0x81 bit 0
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    a_rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack",   a_ack,   8'h00);
    check("mid_rst_data",  a_data,  8'h00);
    check("mid_rst_empty", a_empty, 8'h01);
    check("mid_rst_full",  a_full,  8'h00);
    check("mid_rst_err",   a_err,   8'h00);
    @(negedge clk);
    a_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("post_rst_empty", a_empty, 8'h01);
    send_frame(0, 8'h81, 8, 1'b0, 1, 1'b1);
    wb_read(0, 1'b0, 8'h81, "post_rst_rd");
    check("post_rst_drained", a_empty, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
